spi_mode1_arbiter: RTL

- SPI mode 1 master (CPOL=0, CPHA=1), 8-bit frames, MSB first. Shares a single SPI bus (sclk, ss, MOSI, MISO) between two on-chip requesters.
- Contains a round-robin arbiter, an sclk divider, a frame sequencer FSM and the shift datapath.
- Sits between the system-side requesters and an off-chip or on-chip SPI slave.

---
 rtl/spi_mode1_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/spi_mode1_arbiter.sv
`timescale 1ns/1ps
// SPI mode 1 (CPOL=0, CPHA=1) master whose bus is shared round-robin by two requesters.
// MOSI launches on sclk rising edges and MISO is captured on sclk falling edges, MSB first.
module spi_mode1_arbiter #(
  parameter int CLK_DIV = 4,
  parameter int SS_GAP  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  output logic       rsp0_valid,
  output logic [7:0] rsp0_data,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       rsp1_valid,
  output logic [7:0] rsp1_data,
  output logic       sclk,
  output logic       ss,
  output logic       MOSI,
  input  logic       MISO,
  output logic       busy
);

  localparam int CNT_MAX = (CLK_DIV > SS_GAP) ? CLK_DIV : SS_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(SS_GAP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    half_q, half_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;
  logic          sclk_q, sclk_d;
  logic          ss_q, ss_d;
  logic          mosi_q, mosi_d;
  logic          rsp0_valid_q, rsp0_valid_d;
  logic          rsp1_valid_q, rsp1_valid_d;
  logic [7:0]    rsp0_data_q, rsp0_data_d;
  logic [7:0]    rsp1_data_q, rsp1_data_d;
  logic          grant0, grant1, cnt_last;

  // Ready doubles as the grant; it is also held low while reset is asserted.
  assign grant0 = rst_n && (state_q == IDLE) && req0_valid && (!req1_valid || last_grant_q);
  assign grant1 = rst_n && (state_q == IDLE) && req1_valid && (!req0_valid || !last_grant_q);
  assign cnt_last = (cnt_q == DIV_LAST);

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;
  assign sclk       = sclk_q;
  assign ss         = ss_q;
  assign MOSI       = mosi_q;
  assign busy       = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      half_q       <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      sclk_q       <= 1'b0;
      ss_q         <= 1'b1;
      mosi_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      half_q       <= half_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      sclk_q       <= sclk_d;
      ss_q         <= ss_d;
      mosi_q       <= mosi_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    half_d       = half_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    sclk_d       = sclk_q;
    ss_d         = ss_q;
    mosi_d       = mosi_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;

    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          owner_d      = grant1;
          last_grant_d = grant1;
          tx_d         = grant1 ? req1_data : req0_data;
          ss_d         = 1'b0;
          cnt_d        = '0;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        if (cnt_last) begin
          cnt_d   = '0;
          half_d  = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHIFT: begin
        // Even half-periods end on a rising edge, odd ones on a falling edge.
        if (cnt_last) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          half_d = half_q + 4'd1;
          if (!half_q[0]) begin
            mosi_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end else begin
            rx_d = {rx_q[6:0], MISO};
            if (half_q == 4'd15) begin
              state_d = HOLD;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (cnt_last) begin
          cnt_d   = '0;
          ss_d    = 1'b1;
          mosi_d  = 1'b0;
          state_d = GAP;
          if (owner_q) begin
            rsp1_valid_d = 1'b1;
            rsp1_data_d  = rx_q;
          end else begin
            rsp0_valid_d = 1'b1;
            rsp0_data_d  = rx_q;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
